ifid_fetch_buffer: RTL
======================

Name: ifid_fetch_buffer

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage.
- Captures {PC, PC+4, Inst} triples from fetch into a small circular FIFO and presents the oldest one to decode with a valid/ready handshake.
- Back-pressures fetch when full.
- Discards all buffered instructions when a taken branch/jump resolves in MEM.

Parameters:
- DEPTH, 2, number of entries; power of two, >= 2.
- AW, 1, pointer width = log2(DEPTH); must match DEPTH.
- NOP_INST, 32'h0000_0000, instruction word driven on ID_Inst when buffer empty.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Clr  in  1  synchronous reset, active-high.
- IF_Valid  in  1  fetch presents a valid triple this cycle.
- IF_PC  in  32  PC of fetched instruction.
- IF_PC4  in  32  PC+4 of fetched instruction.
- IF_Inst  in  32  fetched instruction word.
- IF_Ready  out  1  buffer accepts a push this cycle; fetch must hold its PC when low.
- MEM_PCSrc  in  1  taken branch/jump in MEM; flushes the buffer.
- ID_Ready  in  1  decode consumes the head entry this cycle.
- ID_Valid  out  1  head entry valid.
- ID_PC  out  32  head entry PC.
- ID_PC4  out  32  head entry PC+4.
- ID_Inst  out  32  head entry instruction, or NOP_INST when empty.
- Count  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array DEPTH x 96 bits, wr_ptr[AW-1:0], rd_ptr[AW-1:0], cnt[AW:0].
- Clr is highest priority. On the clock edge with Clr=1, wr_ptr, rd_ptr and cnt go to 0; storage contents are don't-care.
- Outputs during and after reset: ID_Valid=0, ID_Inst=NOP_INST, ID_PC=0, ID_PC4=0, Count=0.
- IF_Ready = (cnt != DEPTH) && !Clr. It is combinational from registered state plus Clr and never depends on ID_Ready: there is no pass-through when full.
- push = IF_Valid && IF_Ready && !MEM_PCSrc.
- pop = ID_Valid && ID_Ready && !MEM_PCSrc.
- ID_Valid = (cnt != 0).
- When empty, ID_PC and ID_PC4 are 0 and ID_Inst is NOP_INST. When non-empty, all three come from storage[rd_ptr].
- Push: writes storage[wr_ptr]; wr_ptr increments modulo DEPTH, wrapping naturally at AW bits.
- Pop: rd_ptr increments modulo DEPTH.
- cnt update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- Latency: a triple pushed into an empty buffer appears on ID_* with ID_Valid=1 in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < cnt < DEPTH: both occur, cnt is unchanged, and the head advances to the next-oldest entry.
- When full: IF_Ready=0, so a push cannot occur. A pop that cycle frees one slot and IF_Ready=1 in the next cycle.
- When empty: a pop cannot occur because ID_Valid=0, and an ID_Ready held high has no effect.
- Flush (MEM_PCSrc=1, Clr=0): next edge sets cnt=0 and rd_ptr=wr_ptr. Any push or pop that cycle is suppressed, and ID_Valid=0 in the next cycle. The first post-flush push is the target fetch and is issued by fetch in the cycle after the flush.
- Flush and Clr together: Clr wins, with the same resulting state.
- No state machine beyond the occupancy counter. Full/empty are derived from cnt, never from pointer comparison alone.

Optional Feature:
- Macro: IFID_PERF_EN.
- Defined: adds output Stall_Cnt (32-bit) and output Flush_Cnt (16-bit). Both are cleared by Clr and saturate at all-ones, never wrapping.
  - Stall_Cnt increments on each cycle with IF_Valid && !IF_Ready && !Clr.
  - Flush_Cnt increments on each flush cycle where cnt != 0 or IF_Valid=1, i.e. instructions were actually discarded.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: assert Clr for 2 cycles, release -> ID_Valid=0, ID_Inst=32'h0, Count=0, IF_Ready=1.
- Single push: IF_Valid=1, PC=0x0000_0040, PC4=0x0000_0044, Inst=0x2008_0005 for one cycle, ID_Ready=0 -> next cycle ID_Valid=1, ID_PC=0x40, ID_Inst=0x2008_0005, Count=1.
- Fill and back-pressure (DEPTH=2): push PC=0x0, 0x4, 0x8 on consecutive cycles with ID_Ready=0 -> Count=2 and IF_Ready=0 after the second push; 0x8 is not captured. Raise ID_Ready for one cycle -> head becomes 0x4, IF_Ready=1, then 0x8 is accepted.
- Streaming: IF_Valid=1 and ID_Ready=1 continuously, PC stepping by 4 from 0x100 over 10 cycles -> ID_PC sequence 0x100, 0x104, ... in order with one-cycle latency; Count stays 1; pointers wrap with no loss or duplication.
- Flush with full buffer: Count=2, assert MEM_PCSrc=1 with IF_Valid=1, PC=0x200 -> next cycle Count=0, ID_Valid=0, and 0x200 is not stored. With IFID_PERF_EN, Flush_Cnt=1.
- Clr mid-stream: Count=1 and push/pop active, assert Clr -> next cycle Count=0, ID_Valid=0, and IF_Ready=0 while Clr is high. With IFID_PERF_EN, Stall_Cnt=0.

Source files
------------

// File: rtl/ifid_fetch_buffer_if.sv
// Fetch/decode handshake bundle for ifid_fetch_buffer.
// Optional perf counter signals appear only when IFID_PERF_EN is defined.
interface ifid_fetch_buffer_if #(
    parameter int unsigned AW = 1
);
    logic          IF_Valid;
    logic [31:0]   IF_PC;
    logic [31:0]   IF_PC4;
    logic [31:0]   IF_Inst;
    logic          IF_Ready;
    logic          MEM_PCSrc;
    logic          ID_Ready;
    logic          ID_Valid;
    logic [31:0]   ID_PC;
    logic [31:0]   ID_PC4;
    logic [31:0]   ID_Inst;
    logic [AW:0]   Count;
`ifdef IFID_PERF_EN
    logic [31:0]   Stall_Cnt;
    logic [15:0]   Flush_Cnt;
`endif

    // Driver side: fetch, MEM-stage redirect and decode.
    modport master (
        output IF_Valid, IF_PC, IF_PC4, IF_Inst, MEM_PCSrc, ID_Ready,
        input  IF_Ready, ID_Valid, ID_PC, ID_PC4, ID_Inst, Count
`ifdef IFID_PERF_EN
        , input Stall_Cnt, Flush_Cnt
`endif
    );

    // Buffer side.
    modport slave (
        input  IF_Valid, IF_PC, IF_PC4, IF_Inst, MEM_PCSrc, ID_Ready,
        output IF_Ready, ID_Valid, ID_PC, ID_PC4, ID_Inst, Count
`ifdef IFID_PERF_EN
        , output Stall_Cnt, Flush_Cnt
`endif
    );
endinterface

// File: rtl/ifid_fetch_buffer.sv
// IF/ID decoupling FIFO of {PC, PC+4, Inst} triples with flush on taken branch.
// Define IFID_PERF_EN to add saturating stall/flush counters.
module ifid_fetch_buffer #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned AW       = 1,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                 Clk,
    input  logic                 Clr,
    ifid_fetch_buffer_if.slave   bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [95:0]   mem_q [DEPTH];
    logic [95:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic          if_ready;
    logic          id_valid;
    logic          push;
    logic          pop;
    logic [95:0]   head;

    assign if_ready = (cnt_q != FULL_CNT) && !Clr;
    assign id_valid = (cnt_q != '0);
    assign push     = bus.IF_Valid && if_ready && !bus.MEM_PCSrc;
    assign pop      = id_valid && bus.ID_Ready && !bus.MEM_PCSrc;
    assign head     = mem_q[rd_ptr_q];

    assign bus.IF_Ready = if_ready;
    assign bus.ID_Valid = id_valid;
    assign bus.ID_PC    = id_valid ? head[95:64] : '0;
    assign bus.ID_PC4   = id_valid ? head[63:32] : '0;
    assign bus.ID_Inst  = id_valid ? head[31:0]  : NOP_INST;
    assign bus.Count    = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.MEM_PCSrc) begin
            // Flush: drop everything by aligning the read pointer to the write pointer.
            cnt_d    = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {bus.IF_PC, bus.IF_PC4, bus.IF_Inst};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + (AW+1)'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge Clk) begin
        mem_q <= mem_d;
    end

`ifdef IFID_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.IF_Valid && !if_ready && !Clr && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bus.MEM_PCSrc && (id_valid || bus.IF_Valid) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.Stall_Cnt = stall_cnt_q;
    assign bus.Flush_Cnt = flush_cnt_q;
`endif
endmodule
